// File: rtl/tick_report_pkg.sv
// Shared types and ASCII constants for the once-per-second seconds report formatter.
// Optional build macro used by the formatter: TICK_REPORT_BLANK_ZERO_EN (leading-zero blanking).
package tick_report_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIGIT = 2'd1,
        ST_CR    = 2'd2,
        ST_LF    = 2'd3
    } state_e;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    function automatic logic [7:0] ascii_digit(input bcd_digit_t d);
        return ASCII_ZERO + {4'h0, d};
    endfunction

endpackage

// File: rtl/tick_report_fmt_bcd_counter.sv
// Free-running BCD counter with a per-digit ripple carry; all-nines wraps silently to zero.
// next_count is the value count will take after an increment, used to snapshot a line.
module bcd_counter
    import tick_report_pkg::*;
#(
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc,
    output logic [4*DIGITS-1:0]   count,
    output logic [4*DIGITS-1:0]   next_count
);

    logic [4*DIGITS-1:0] count_q;
    logic [DIGITS:0]     carry;

    assign carry[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_t digit;
        assign digit                  = count_q[4*g +: 4];
        assign carry[g+1]             = carry[g] & (digit == 4'd9);
        assign next_count[4*g +: 4]   = carry[g] ? ((digit == 4'd9) ? 4'd0 : digit + 4'd1)
                                                 : digit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= next_count;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/tick_report_fmt.sv
// Formats the BCD seconds count as "<DIGITS digits>\r\n" and streams it to the UART one byte per transfer.
// Build macro TICK_REPORT_BLANK_ZERO_EN sends leading zeros (except the last digit) as spaces.
module tick_report_fmt
    import tick_report_pkg::*;
#(
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  strobe,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  overrun,
    output logic [4*DIGITS-1:0]   sec_count
);

    localparam int                IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0]  IDX_TOP = IDX_W'(DIGITS - 1);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [4*DIGITS-1:0]  line_q, line_d;
    logic                 busy_q, busy_d;
    logic                 overrun_q, overrun_d;
    logic [4*DIGITS-1:0]  count, count_next;
    logic                 xfer;
    bcd_digit_t           cur_digit;
    logic                 blank;

    bcd_counter #(.DIGITS(DIGITS)) u_counter (
        .clk        (clk),
        .rst        (rst),
        .inc        (strobe),
        .count      (count),
        .next_count (count_next)
    );

    // Handshake: tx_valid is high in every non-idle state and, together with tx_data,
    // holds until tx_valid & tx_ready; a byte moves on exactly those cycles.
    assign xfer = busy_q & tx_ready;

    always_comb begin
        cur_digit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) cur_digit = line_q[4*i +: 4];
        end
    end

`ifdef TICK_REPORT_BLANK_ZERO_EN
    logic lead_zero;

    // A digit is blank when it and every more-significant digit are zero.
    always_comb begin
        lead_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if ((IDX_W'(i) >= idx_q) && (line_q[4*i +: 4] != 4'd0)) lead_zero = 1'b0;
        end
        blank = lead_zero & (idx_q != '0);
    end
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        line_d  = line_q;
        unique case (state_q)
            ST_IDLE: begin
                if (strobe) begin
                    state_d = ST_DIGIT;
                    idx_d   = IDX_TOP;
                    line_d  = count_next;
                end
            end
            ST_DIGIT: begin
                if (xfer) begin
                    if (idx_q == '0) state_d = ST_CR;
                    else             idx_d   = idx_q - IDX_W'(1);
                end
            end
            ST_CR: begin
                if (xfer) state_d = ST_LF;
            end
            ST_LF: begin
                if (xfer) begin
                    if (strobe) begin
                        state_d = ST_DIGIT;
                        idx_d   = IDX_TOP;
                        line_d  = count_next;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d    = (state_d != ST_IDLE);
        // Only an idle FSM or the final LF transfer can accept a new line.
        overrun_d = overrun_q | (strobe & busy_q & ~((state_q == ST_LF) & xfer));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            line_q    <= '0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            line_q    <= line_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        tx_data = 8'h00;
        unique case (state_q)
            ST_IDLE:  tx_data = 8'h00;
            ST_DIGIT: tx_data = blank ? ASCII_SPACE : ascii_digit(cur_digit);
            ST_CR:    tx_data = ASCII_CR;
            ST_LF:    tx_data = ASCII_LF;
            default:  tx_data = 8'h00;
        endcase
    end

    assign tx_valid  = busy_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;
    assign sec_count = count;

endmodule

// File: tb/tb_tick_report_fmt.sv
// Bench for tick_report_fmt: a 5-digit and a 2-digit instance share one stimulus stream and
// are each compared every cycle against a line/byte-level reference model.
module tb_tick_report_fmt;

    localparam int D0 = 5;
    localparam int D1 = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            strobe;
    logic            tx_ready;
    logic [7:0]      tx_data0, tx_data1;
    logic            valid0, valid1, busy0, busy1, ovr0, ovr1;
    logic [4*D0-1:0] sec0;
    logic [4*D1-1:0] sec1;

    int n_vec = 0;
    int n_err = 0;

    // reference model state, index 0 = 5-digit unit, 1 = 2-digit unit
    int         m_digits [2] = '{D0, D1};
    int         m_cnt    [2];
    bit         m_act    [2];
    int         m_pos    [2];
    bit         m_ovr    [2];
    logic [7:0] m_line   [2][10];

    always #5 clk = ~clk;

    tick_report_fmt #(.DIGITS(D0)) u_dut0 (
        .clk(clk), .rst(rst), .strobe(strobe),
        .tx_data(tx_data0), .tx_valid(valid0), .tx_ready(tx_ready),
        .busy(busy0), .overrun(ovr0), .sec_count(sec0)
    );

    tick_report_fmt #(.DIGITS(D1)) u_dut1 (
        .clk(clk), .rst(rst), .strobe(strobe),
        .tx_data(tx_data1), .tx_valid(valid1), .tx_ready(tx_ready),
        .busy(busy1), .overrun(ovr1), .sec_count(sec1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int pow10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [31:0] model_bcd(input int u);
        logic [31:0] r = '0;
        for (int k = 0; k < m_digits[u]; k++) r[4*k +: 4] = 4'((m_cnt[u] / pow10(k)) % 10);
        return r;
    endfunction

    task automatic model_start(input int u);
        int d = m_digits[u];
        m_act[u] = 1'b1;
        m_pos[u] = 0;
        for (int k = 0; k < d; k++) begin
            m_line[u][k] = 8'(8'h30 + (m_cnt[u] / pow10(d - 1 - k)) % 10);
`ifdef TICK_REPORT_BLANK_ZERO_EN
            if (k < d - 1 && (m_cnt[u] / pow10(d - 1 - k)) == 0) m_line[u][k] = 8'h20;
`endif
        end
        m_line[u][d]     = 8'h0D;
        m_line[u][d + 1] = 8'h0A;
    endtask

    task automatic model_step(input bit s, input bit r, input bit rs);
        for (int u = 0; u < 2; u++) begin
            bit was_act;
            bit last;
            if (rs) begin
                m_cnt[u] = 0; m_act[u] = 1'b0; m_pos[u] = 0; m_ovr[u] = 1'b0;
                continue;
            end
            was_act = m_act[u];
            last    = 1'b0;
            if (m_act[u] && r) begin
                if (m_pos[u] == m_digits[u] + 1) begin
                    last = 1'b1; m_act[u] = 1'b0; m_pos[u] = 0;
                end else begin
                    m_pos[u]++;
                end
            end
            if (s) begin
                m_cnt[u] = (m_cnt[u] + 1) % pow10(m_digits[u]);
                if (!was_act || last) model_start(u);
                else                  m_ovr[u] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        check_eq("valid0",   32'(valid0),   32'(m_act[0]));
        check_eq("data0",    32'(tx_data0), m_act[0] ? 32'(m_line[0][m_pos[0]]) : 32'h0);
        check_eq("busy0",    32'(busy0),    32'(m_act[0]));
        check_eq("overrun0", 32'(ovr0),     32'(m_ovr[0]));
        check_eq("sec0",     32'(sec0),     model_bcd(0));
        check_eq("valid1",   32'(valid1),   32'(m_act[1]));
        check_eq("data1",    32'(tx_data1), m_act[1] ? 32'(m_line[1][m_pos[1]]) : 32'h0);
        check_eq("busy1",    32'(busy1),    32'(m_act[1]));
        check_eq("overrun1", 32'(ovr1),     32'(m_ovr[1]));
        check_eq("sec1",     32'(sec1),     model_bcd(1));
    endtask

    // Drive one cycle of inputs, advance the model, then sample on the falling edge.
    task automatic cycle(input bit s, input bit r, input bit rs);
        rst      = rs;
        strobe   = s;
        tx_ready = r;
        model_step(s, r, rs);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst = 1'b1; strobe = 1'b0; tx_ready = 1'b0;
        @(negedge clk);

        repeat (3) cycle(0, 0, 1);

        // single line at full rate
        cycle(1, 1, 0);
        repeat (9) cycle(0, 1, 0);

        // reset after two bytes aborts the line
        cycle(1, 1, 0);
        cycle(0, 1, 0);
        cycle(0, 1, 0);
        cycle(0, 1, 1);
        repeat (3) cycle(0, 1, 0);

        // backpressure: ready 1,0,0 repeating
        cycle(1, 0, 0);
        for (int i = 0; i < 30; i++) cycle(0, (i % 3) == 0, 0);

        // overrun while the third byte is pending
        cycle(0, 0, 1);
        cycle(1, 1, 0);
        cycle(0, 1, 0);
        cycle(0, 1, 0);
        cycle(1, 0, 0);
        repeat (10) cycle(0, 1, 0);
        cycle(1, 1, 0);
        repeat (10) cycle(0, 1, 0);

        // strobe coincident with the 5-digit LF transfer
        cycle(0, 0, 1);
        cycle(1, 1, 0);
        repeat (6) cycle(0, 1, 0);
        cycle(1, 1, 0);
        repeat (10) cycle(0, 1, 0);

        // 99 stalled strobes, drain, then one more: the 2-digit unit wraps to "00"
        cycle(0, 0, 1);
        repeat (99) cycle(1, 0, 0);
        repeat (10) cycle(0, 1, 0);
        cycle(1, 1, 0);
        repeat (10) cycle(0, 1, 0);

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 999) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
